// File: rtl/neuron_step_sequencer.sv
// Time-multiplexed v/w state sweep around one shared Izhikevich integrator, with a spike-id FIFO.
// Optional feature macro SEQ_SPIKE_TS_EN adds a 16-bit step timestamp to every queued spike (port spk_ts).
module neuron_step_sequencer #(
   parameter int WIDTH      = 32,
   parameter int N_NEURONS  = 16,
   parameter int AW         = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   output logic [AW-1:0]    I_addr,
   input  logic [WIDTH-1:0] I_data,
   output logic [WIDTH-1:0] int_I,
   output logic [WIDTH-1:0] int_v_old,
   output logic [WIDTH-1:0] int_w_old,
   input  logic [WIDTH-1:0] int_v_new,
   input  logic [WIDTH-1:0] int_w_new,
   input  logic             int_fire,
   output logic             spk_valid,
   output logic [AW-1:0]    spk_id,
   input  logic             spk_ready,
   output logic             busy,
   output logic             done,
   output logic             overrun
`ifdef SEQ_SPIKE_TS_EN
  ,output logic [15:0]      spk_ts
`endif
);

   localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW  = FAW + 1;
   localparam logic [WIDTH-1:0] V_RESET = WIDTH'(32'hFFBF_0000);
   localparam logic [WIDTH-1:0] W_RESET = WIDTH'(32'hFFF3_0000);

   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_r, state_nxt_s;
   logic [AW-1:0]    idx_r, idx_nxt_s;
   logic [WIDTH-1:0] v_r [N_NEURONS];
   logic [WIDTH-1:0] w_r [N_NEURONS];
   logic [AW-1:0]    fifo_id_r [FIFO_DEPTH];
   logic [FAW-1:0]   wr_ptr_r, rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             done_r, overrun_r;
   logic             full_s, empty_s, stall_s, adv_s, push_s, pop_s, last_s;

   function automatic logic [FAW-1:0] ptr_inc(input logic [FAW-1:0] p);
      return (p == FAW'(FIFO_DEPTH - 1)) ? {FAW{1'b0}} : p + FAW'(1);
   endfunction

   // Full is judged on the pre-pop occupancy, so a full FIFO blocks a push even when popping.
   assign full_s  = (count_r == CW'(FIFO_DEPTH));
   assign empty_s = (count_r == {CW{1'b0}});
   assign stall_s = (state_r == RUN) && int_fire && full_s;
   assign adv_s   = (state_r == RUN) && !stall_s;
   assign push_s  = adv_s && int_fire;
   assign pop_s   = !empty_s && spk_ready;
   assign last_s  = (idx_r == AW'(N_NEURONS - 1));

   // idx_r is held at 0 in IDLE, so the integrator view shows neuron 0 there.
   assign I_addr    = idx_r;
   assign int_I     = I_data;
   assign int_v_old = v_r[idx_r];
   assign int_w_old = w_r[idx_r];
   assign spk_valid = !empty_s;
   assign spk_id    = empty_s ? {AW{1'b0}} : fifo_id_r[rd_ptr_r];
   assign busy      = (state_r == RUN);
   assign done      = done_r;
   assign overrun   = overrun_r;

   // Next-state and sweep index.
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;
      case (state_r)
         IDLE: begin
            if (step) begin
               state_nxt_s = RUN;
               idx_nxt_s   = {AW{1'b0}};
            end else begin
               state_nxt_s = IDLE;
               idx_nxt_s   = {AW{1'b0}};
            end
         end
         RUN: begin
            if (adv_s && last_s) begin
               state_nxt_s = IDLE;
               idx_nxt_s   = {AW{1'b0}};
            end else if (adv_s) begin
               idx_nxt_s   = idx_r + AW'(1);
            end else begin
               idx_nxt_s   = idx_r;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            idx_nxt_s   = {AW{1'b0}};
         end
      endcase
   end

   // FSM state, index and the done/overrun pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         idx_r     <= {AW{1'b0}};
         done_r    <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         idx_r     <= idx_nxt_s;
         done_r    <= adv_s && last_s;
         overrun_r <= step && (state_r == RUN);
      end
   end

   // Neuron state array write-back.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            v_r[i] <= V_RESET;
            w_r[i] <= W_RESET;
         end
      end else if (adv_s) begin
         v_r[idx_r] <= int_v_new;
         w_r[idx_r] <= int_w_new;
      end
   end

`ifdef SEQ_SPIKE_TS_EN
   logic [15:0] ts_r;
   logic [15:0] fifo_ts_r [FIFO_DEPTH];

   assign spk_ts = empty_s ? 16'h0000 : fifo_ts_r[rd_ptr_r];

   // Step counter, advanced once per completed sweep.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_r <= 16'h0000;
      end else if (done_r) begin
         ts_r <= ts_r + 16'h0001;
      end
   end
`endif

   // Spike FIFO storage, pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_id_r[i] <= {AW{1'b0}};
`ifdef SEQ_SPIKE_TS_EN
            fifo_ts_r[i] <= 16'h0000;
`endif
         end
         wr_ptr_r <= {FAW{1'b0}};
         rd_ptr_r <= {FAW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            fifo_id_r[wr_ptr_r] <= idx_r;
`ifdef SEQ_SPIKE_TS_EN
            fifo_ts_r[wr_ptr_r] <= ts_r;
`endif
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_step_sequencer.sv
// Self-checking bench for neuron_step_sequencer: stub integrator, cycle model and spike scoreboard.
module tb_neuron_step_sequencer;

   localparam int N  = 16;
   localparam int FD = 4;
   localparam logic [31:0] V_RST = 32'hFFBF_0000;
   localparam logic [31:0] W_RST = 32'hFFF3_0000;
   localparam logic [31:0] THR   = 32'h001E_0000;
   localparam logic [31:0] W_INC = 32'h0000_4000;
   localparam logic [31:0] BIG   = 32'h0100_0000;

   logic        clk = 1'b0;
   logic        rst, step, spk_ready, force_fire;
   logic [3:0]  I_addr, spk_id;
   logic [31:0] I_data, int_I, int_v_old, int_w_old, int_v_new, int_w_new;
   logic        int_fire, spk_valid, busy, done, overrun;
`ifdef SEQ_SPIKE_TS_EN
   logic [15:0] spk_ts;
`endif

   logic [31:0] cur_tab [N];

   typedef struct packed {
      logic [3:0]  id;
      logic [15:0] ts;
   } sp_t;

   sp_t         sb_q [$];
   int          ts_hist [$];
   logic [31:0] m_v [N];
   logic [31:0] m_w [N];
   logic        m_busy, m_done, m_ovr, e_fire, e_stall, e_adv;
   logic [3:0]  m_idx;
   logic [15:0] m_ts;
   int          n_checks = 0;
   int          n_pass   = 0;
   int          pop_cnt  = 0;
   int          last_pop_id = -1;

   always #5 clk = ~clk;

   function automatic logic stub_fire(input logic [31:0] v, input logic [31:0] i, input logic ff);
      logic [31:0] s;
      s = v + i;
      return ff || ($signed(s) >= $signed(THR));
   endfunction

   assign I_data    = cur_tab[I_addr];
   assign int_fire  = stub_fire(int_v_old, int_I, force_fire);
   assign int_v_new = int_fire ? V_RST : int_v_old + int_I;
   assign int_w_new = int_w_old + W_INC;

   neuron_step_sequencer dut (
      .clk(clk), .rst(rst), .step(step), .I_addr(I_addr), .I_data(I_data),
      .int_I(int_I), .int_v_old(int_v_old), .int_w_old(int_w_old),
      .int_v_new(int_v_new), .int_w_new(int_w_new), .int_fire(int_fire),
      .spk_valid(spk_valid), .spk_id(spk_id), .spk_ready(spk_ready),
      .busy(busy), .done(done), .overrun(overrun)
`ifdef SEQ_SPIKE_TS_EN
     ,.spk_ts(spk_ts)
`endif
   );

   // Cycle model and spike scoreboard, evaluated mid-cycle while inputs are stable.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         for (int i = 0; i < N; i++) begin
            m_v[i] = V_RST;
            m_w[i] = W_RST;
         end
         m_busy = 1'b0; m_done = 1'b0; m_ovr = 1'b0; m_idx = 4'd0; m_ts = 16'd0;
      end else begin
         n_checks++; if (busy !== m_busy) $display("FAIL mon_busy got %b exp %b t=%0t", busy, m_busy, $time); else n_pass++;
         n_checks++; if (done !== m_done) $display("FAIL mon_done got %b exp %b t=%0t", done, m_done, $time); else n_pass++;
         n_checks++; if (overrun !== m_ovr) $display("FAIL mon_overrun got %b exp %b t=%0t", overrun, m_ovr, $time); else n_pass++;
         n_checks++; if (spk_valid !== (sb_q.size() != 0)) $display("FAIL mon_spk_valid got %b exp %b t=%0t", spk_valid, sb_q.size() != 0, $time); else n_pass++;
         n_checks++; if (I_addr !== (m_busy ? m_idx : 4'd0)) $display("FAIL mon_I_addr got %0d exp %0d t=%0t", I_addr, m_busy ? m_idx : 4'd0, $time); else n_pass++;
         if (m_busy) begin
            n_checks++; if (int_v_old !== m_v[m_idx]) $display("FAIL mon_v_old[%0d] got %h exp %h", m_idx, int_v_old, m_v[m_idx]); else n_pass++;
            n_checks++; if (int_w_old !== m_w[m_idx]) $display("FAIL mon_w_old[%0d] got %h exp %h", m_idx, int_w_old, m_w[m_idx]); else n_pass++;
         end
         e_fire  = m_busy && stub_fire(m_v[m_idx], cur_tab[m_idx], force_fire);
         e_stall = e_fire && (sb_q.size() == FD);
         e_adv   = m_busy && !e_stall;
         if (sb_q.size() != 0 && spk_ready) begin
            n_checks++; if (spk_id !== sb_q[0].id) $display("FAIL sb_spk_id got %0d exp %0d", spk_id, sb_q[0].id); else n_pass++;
`ifdef SEQ_SPIKE_TS_EN
            n_checks++; if (spk_ts !== sb_q[0].ts) $display("FAIL sb_spk_ts got %0d exp %0d", spk_ts, sb_q[0].ts); else n_pass++;
            ts_hist.push_back(int'(spk_ts));
`endif
            pop_cnt++;
            last_pop_id = int'(spk_id);
            void'(sb_q.pop_front());
         end
         m_ovr = m_busy && step;
         if (m_done) m_ts = m_ts + 16'd1;
         m_done = e_adv && (m_idx == 4'd15);
         if (e_adv) begin
            m_w[m_idx] = m_w[m_idx] + W_INC;
            m_v[m_idx] = e_fire ? V_RST : m_v[m_idx] + cur_tab[m_idx];
            if (e_fire) sb_q.push_back('{id: m_idx, ts: m_ts});
         end
         if (m_busy) begin
            if (e_adv && m_idx == 4'd15) begin m_busy = 1'b0; m_idx = 4'd0; end
            else if (e_adv) m_idx = m_idx + 4'd1;
         end else if (step) begin
            m_busy = 1'b1; m_idx = 4'd0;
         end
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; step = 1'b0; spk_ready = 1'b0; force_fire = 1'b0;
      for (int i = 0; i < N; i++) cur_tab[i] = 32'd0;
      cyc(); cyc();
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
      n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b exp 0", overrun); else n_pass++;
      n_checks++; if (spk_valid !== 1'b0) $display("FAIL reset_spk_valid got %b exp 0", spk_valid); else n_pass++;
      n_checks++; if (spk_id !== 4'd0) $display("FAIL reset_spk_id got %0d exp 0", spk_id); else n_pass++;
      n_checks++; if (I_addr !== 4'd0) $display("FAIL reset_I_addr got %0d exp 0", I_addr); else n_pass++;
      n_checks++; if (int_v_old !== V_RST) $display("FAIL reset_v got %h exp %h", int_v_old, V_RST); else n_pass++;
      n_checks++; if (int_w_old !== W_RST) $display("FAIL reset_w got %h exp %h", int_w_old, W_RST); else n_pass++;
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_quiet_sweep();
      int cnt;
      spk_ready = 1'b1;
      step = 1'b1; cyc(); step = 1'b0;
      cnt = 0;
      while (busy && cnt < 40) begin cnt++; cyc(); end
      n_checks++; if (cnt != 16) $display("FAIL quiet_busy_cycles got %0d exp 16", cnt); else n_pass++;
      n_checks++; if (done !== 1'b1) $display("FAIL quiet_done got %b exp 1", done); else n_pass++;
      n_checks++; if (pop_cnt != 0) $display("FAIL quiet_spikes got %0d exp 0", pop_cnt); else n_pass++;
      cyc();
      n_checks++; if (done !== 1'b0) $display("FAIL quiet_done_pulse got %b exp 0", done); else n_pass++;
   endtask

   task automatic test_fire_n3();
      int cnt, s;
      cur_tab[3] = BIG; spk_ready = 1'b1; pop_cnt = 0; s = 0;
      while (pop_cnt == 0 && s < 4) begin
         step = 1'b1; cyc(); step = 1'b0;
         cnt = 0;
         while (!done && cnt < 60) begin cnt++; cyc(); end
         cyc(); cyc();
         s++;
      end
      n_checks++; if (last_pop_id != 3) $display("FAIL fire_spike_id got %0d exp 3", last_pop_id); else n_pass++;
      step = 1'b1; cyc(); step = 1'b0;
      cnt = 0;
      while (!(busy && I_addr == 4'd3) && cnt < 20) begin cnt++; cyc(); end
      n_checks++; if (int_v_old !== V_RST) $display("FAIL fire_v3_reset got %h exp %h", int_v_old, V_RST); else n_pass++;
      cnt = 0;
      while (!done && cnt < 60) begin cnt++; cyc(); end
      cyc(); cyc();
      cur_tab[3] = 32'd0;
   endtask

   task automatic test_stall();
      int cnt;
      force_fire = 1'b1; spk_ready = 1'b0; pop_cnt = 0;
      step = 1'b1; cyc(); step = 1'b0;
      repeat (10) cyc();
      n_checks++; if (busy !== 1'b1) $display("FAIL stall_busy got %b exp 1", busy); else n_pass++;
      n_checks++; if (I_addr !== 4'd4) $display("FAIL stall_idx got %0d exp 4", I_addr); else n_pass++;
      n_checks++; if (spk_id !== 4'd0) $display("FAIL stall_head got %0d exp 0", spk_id); else n_pass++;
      spk_ready = 1'b1;
      cnt = 0;
      while (!done && cnt < 100) begin cnt++; cyc(); end
      n_checks++; if (done !== 1'b1) $display("FAIL stall_done got %b exp 1", done); else n_pass++;
      cnt = 0;
      while (spk_valid && cnt < 20) begin cnt++; cyc(); end
      n_checks++; if (pop_cnt != 16) $display("FAIL stall_pop_count got %0d exp 16", pop_cnt); else n_pass++;
      n_checks++; if (last_pop_id != 15) $display("FAIL stall_last_id got %0d exp 15", last_pop_id); else n_pass++;
      force_fire = 1'b0;
      cyc();
   endtask

   task automatic test_overrun();
      int dones, ovrs;
      step = 1'b1; cyc(); step = 1'b0;
      repeat (4) cyc();
      step = 1'b1; cyc(); step = 1'b0;
      n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_pulse got %b exp 1", overrun); else n_pass++;
      dones = 0; ovrs = 0;
      repeat (30) begin cyc(); if (done) dones++; if (overrun) ovrs++; end
      n_checks++; if (dones != 1) $display("FAIL ovr_done_count got %0d exp 1", dones); else n_pass++;
      n_checks++; if (ovrs != 0) $display("FAIL ovr_extra_pulses got %0d exp 0", ovrs); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int cnt;
      step = 1'b1; cyc(); step = 1'b0;
      cnt = 0;
      while (!(busy && I_addr == 4'd15) && cnt < 30) begin cnt++; cyc(); end
      step = 1'b1; cyc();
      n_checks++; if (done !== 1'b1) $display("FAIL b2b_done got %b exp 1", done); else n_pass++;
      n_checks++; if (overrun !== 1'b1) $display("FAIL b2b_last_overrun got %b exp 1", overrun); else n_pass++;
      cyc(); step = 1'b0;
      n_checks++; if (busy !== 1'b1) $display("FAIL b2b_accept got %b exp 1", busy); else n_pass++;
      n_checks++; if (overrun !== 1'b0) $display("FAIL b2b_no_overrun got %b exp 0", overrun); else n_pass++;
      cnt = 0;
      while (!done && cnt < 40) begin cnt++; cyc(); end
      cyc();
   endtask

   task automatic test_reset_mid();
      int cnt;
      cur_tab[2] = BIG; spk_ready = 1'b0;
      step = 1'b1; cyc(); step = 1'b0;
      cnt = 0;
      while (!(busy && I_addr == 4'd7) && cnt < 30) begin cnt++; cyc(); end
      n_checks++; if (spk_valid !== 1'b1) $display("FAIL rmid_pre_valid got %b exp 1", spk_valid); else n_pass++;
      rst = 1'b1; #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else n_pass++;
      n_checks++; if (I_addr !== 4'd0) $display("FAIL rmid_I_addr got %0d exp 0", I_addr); else n_pass++;
      n_checks++; if (spk_valid !== 1'b0) $display("FAIL rmid_spk_valid got %b exp 0", spk_valid); else n_pass++;
      n_checks++; if (int_v_old !== V_RST) $display("FAIL rmid_v got %h exp %h", int_v_old, V_RST); else n_pass++;
      n_checks++; if (int_w_old !== W_RST) $display("FAIL rmid_w got %h exp %h", int_w_old, W_RST); else n_pass++;
      cyc(); rst = 1'b0; cur_tab[2] = 32'd0; spk_ready = 1'b1;
      cyc();
   endtask

`ifdef SEQ_SPIKE_TS_EN
   task automatic test_timestamp();
      int cnt;
      cur_tab[0] = BIG; ts_hist.delete();
      repeat (3) begin
         step = 1'b1; cyc(); step = 1'b0;
         cnt = 0;
         while (!done && cnt < 40) begin cnt++; cyc(); end
         cyc();
      end
      n_checks++; if (ts_hist.size() != 3) $display("FAIL ts_count got %0d exp 3", ts_hist.size()); else n_pass++;
      for (int i = 0; i < ts_hist.size(); i++) begin
         n_checks++; if (ts_hist[i] != i) $display("FAIL ts_seq[%0d] got %0d exp %0d", i, ts_hist[i], i); else n_pass++;
      end
      cur_tab[0] = 32'd0;
   endtask
`endif

   initial begin
      test_reset();
      test_quiet_sweep();
      test_fire_n3();
      test_stall();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
`ifdef SEQ_SPIKE_TS_EN
      test_timestamp();
`endif
      repeat (3) cyc();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
